// File: rtl/i2c_pkg.sv
// I2C target shared definitions.
//   state_e   : protocol FSM states of the target.
//   BYTE_BITS : bits per I2C byte (excluding the ACK bit).
//   shift_in  : MSB-first receive shift helper.
package i2c_pkg;

    localparam int unsigned BYTE_BITS = 8;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StReg,
        StAckReg,
        StWrData,
        StAckWr,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

    // Append one received bit at the LSB; bytes arrive MSB first.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
        return {cur[6:0], b};
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Register-port interface between the I2C target and a local register file.
//   reg_addr  : current register pointer (target -> regfile)
//   reg_wdata : write data, valid while reg_we is high (target -> regfile)
//   reg_we    : one-cycle write strobe (target -> regfile)
//   reg_rdata : read data for reg_addr (regfile -> target)
// The target uses the master modport, the register file the slave modport.
interface i2c_target_if;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input conditioning and bus event detection.
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   scl_i, sda_i  : raw bus lines
//   sda_o         : synchronized SDA
//   start_det_o   : SDA fell while SCL high (one-cycle pulse)
//   stop_det_o    : SDA rose while SCL high (one-cycle pulse)
//   scl_rise_o    : synchronized SCL rising edge (one-cycle pulse)
//   scl_fall_o    : synchronized SCL falling edge (one-cycle pulse)
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Preset to 1 so an idle bus does not produce a spurious edge out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o       = sda_s;
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder with a register-port back end.
//   CLOCK_50  : system clock
//   reset_n   : asynchronous active-low reset
//   I2C_SCLK  : bus SCL (never stretched)
//   I2C_SDAT  : bus SDA, open drain (0 or z only)
//   busy      : high from an address-matched START until STOP or master NACK
//   reg_port  : register pointer, write strobe/data and read data
// Protocol: [addr,W][reg][data...] writes with auto-increment;
//           [addr,W][reg] Sr [addr,R] reads with auto-increment while the master ACKs.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDRESS = 7'h1A,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic        busy,
    i2c_target_if.master reg_port
);

    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;
    logic sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk_i       (CLOCK_50),
        .rst_ni      (reset_n),
        .scl_i       (I2C_SCLK),
        .sda_i       (I2C_SDAT),
        .sda_o       (sda_s),
        .start_det_o (start_det),
        .stop_det_o  (stop_det),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall)
    );

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;
    logic       last_bit;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sda_oe_q <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sda_oe_q <= sda_oe_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sda_oe_d = sda_oe_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        rx_byte  = shift_in(shreg_q, sda_s);
        last_bit = (bitcnt_q == 4'(BYTE_BITS - 1));

        // Bus conditions outrank bit-level events in the same cycle.
        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            bitcnt_d = '0;
        end else if (start_det) begin
            state_d  = StAddr;
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                end

                StAddr: begin
                    if (scl_rise) begin
                        shreg_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (last_bit) begin
                            bitcnt_d = '0;
                            if (rx_byte[7:1] == SLAVE_ADDRESS) begin
                                state_d = StAckAddr;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = StIdle;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                StReg, StWrData: begin
                    if (scl_rise) begin
                        shreg_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (last_bit) begin
                            bitcnt_d = '0;
                            if (state_q == StReg) begin
                                addr_d  = rx_byte;
                                state_d = StAckReg;
                            end else begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                                state_d = StAckWr;
                            end
                        end
                    end
                end

                // bitcnt 0: waiting for the fall that starts the ACK slot;
                // bitcnt 1: ACK driven, waiting for the fall that ends it.
                StAckAddr, StAckReg, StAckWr: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                            bitcnt_d = 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = '0;
                            case (state_q)
                                StAckAddr: begin
                                    if (rw_q) begin
                                        // First read bit goes out on the fall ending ACK.
                                        state_d  = StRdData;
                                        shreg_d  = {reg_port.reg_rdata[6:0], 1'b0};
                                        sda_oe_d = ~reg_port.reg_rdata[7];
                                        bitcnt_d = 4'd1;
                                    end else begin
                                        state_d = StReg;
                                    end
                                end
                                StAckReg: state_d = StWrData;
                                default: begin
                                    state_d = StWrData;
                                    addr_d  = addr_q + 8'd1;
                                end
                            endcase
                        end
                    end
                end

                // bitcnt counts bits already presented; 0 means load a fresh byte.
                StRdData: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd0) begin
                            shreg_d  = {reg_port.reg_rdata[6:0], 1'b0};
                            sda_oe_d = ~reg_port.reg_rdata[7];
                            bitcnt_d = 4'd1;
                        end else if (bitcnt_q == 4'(BYTE_BITS)) begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = '0;
                            state_d  = StRdAck;
                        end else begin
                            sda_oe_d = ~shreg_q[7];
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end

                StRdAck: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            // Pointer moves now so reg_rdata settles before the next fall.
                            addr_d   = addr_q + 8'd1;
                            bitcnt_d = '0;
                            state_d  = StRdData;
                        end else begin
                            state_d = StWaitStop;
                            busy_d  = 1'b0;
                        end
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    assign I2C_SDAT           = sda_oe_q ? 1'b0 : 1'bz;
    assign busy               = busy_q;
    assign reg_port.reg_addr  = addr_q;
    assign reg_port.reg_wdata = wdata_q;
    assign reg_port.reg_we    = we_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int         Q   = 10;
    localparam logic [6:0] DEV = 7'h1A;

    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic m_sda_low;
    logic busy;
    wire  sda;

    always #10 clk = ~clk;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_if rif ();

    logic [7:0] regfile [256];
    assign rif.reg_rdata = regfile[rif.reg_addr];

    i2c_target #(
        .SLAVE_ADDRESS (DEV),
        .SYNC_STAGES   (2)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .busy     (busy),
        .reg_port (rif)
    );

    // Register-file side: logs every write strobe and applies it.
    logic [15:0] wr_log [256];
    int   wr_count    = 0;
    int   long_pulses = 0;
    int   dut_low_cnt = 0;
    logic we_prev     = 1'b0;

    always @(negedge clk) begin
        if (rif.reg_we) begin
            wr_log[wr_count[7:0]]  <= {rif.reg_addr, rif.reg_wdata};
            regfile[rif.reg_addr] <= rif.reg_wdata;
            wr_count              <= wr_count + 1;
            if (we_prev) long_pulses <= long_pulses + 1;
        end
        we_prev <= rif.reg_we;
        if (sda === 1'b0 && !m_sda_low) dut_low_cnt <= dut_low_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: memory image and expected write sequence.
    logic [7:0]  mem_model [256];
    logic [15:0] exp_log [$];
    int          checked = 0;

    task automatic model_write(input logic [7:0] start, input logic [7:0] data [$]);
        logic [7:0] a;
        a = start;
        foreach (data[i]) begin
            mem_model[a] = data[i];
            exp_log.push_back({a, data[i]});
            a = a + 8'd1;
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wcount"}, 32'(wr_count), 32'(exp_log.size()));
        for (int i = checked; i < exp_log.size() && i < wr_count; i++)
            check({tag, "_wpair"}, 32'(wr_log[i[7:0]]), 32'(exp_log[i]));
        checked = exp_log.size();
    endtask

    // Bus-functional master.
    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wq(Q);
        scl = 1'b1;       wq(Q);
        m_sda_low = 1'b1; wq(Q);
        scl = 1'b0;       wq(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wq(Q);
        scl = 1'b1;       wq(Q);
        m_sda_low = 1'b0; wq(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wq(Q);
        scl = 1'b1;     wq(2 * Q);
        scl = 1'b0;     wq(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wq(Q);
        scl = 1'b1;       wq(Q);
        b = sda;          wq(Q);
        scl = 1'b0;       wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic [7:0] s;
        logic       b;
        s = d;
        repeat (8) begin
            write_bit(s[7]);
            s = s << 1;
        end
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = '0;
        repeat (8) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(~ack);
    endtask

    task automatic do_write(input logic [6:0] dev, input logic [7:0] start,
                            input logic [7:0] data [$], input logic do_stop, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        write_byte({dev, 1'b0}, a);
        if (a) begin
            acks++;
            write_byte(start, a);
            if (a) acks++;
            foreach (data[i]) begin
                write_byte(data[i], a);
                if (a) acks++;
            end
        end
        if (do_stop) i2c_stop();
    endtask

    // Leaves the bus after the final NACK, without STOP.
    task automatic do_read(input logic [7:0] start, input int n,
                           output logic [7:0] got [$], output int acks);
        logic       a;
        logic [7:0] b;
        acks = 0;
        got.delete();
        i2c_start();
        write_byte({DEV, 1'b0}, a); if (a) acks++;
        write_byte(start, a);       if (a) acks++;
        i2c_start();
        write_byte({DEV, 1'b1}, a); if (a) acks++;
        for (int i = 0; i < n; i++) begin
            read_byte(b, i != n - 1);
            got.push_back(b);
        end
    endtask

    logic [7:0] dq [$];
    logic [7:0] got [$];
    logic [7:0] start;
    logic [7:0] ea;
    logic       a;
    int         acks;
    int         n;
    int         low_before;

    initial begin
        rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
        wq(5);
        rst_n = 1'b1;
        wq(5);

        check("rst_busy",  32'(busy), 32'd0);
        check("rst_addr",  32'(rif.reg_addr), 32'd0);
        check("rst_wdata", 32'(rif.reg_wdata), 32'd0);
        check("rst_we",    32'(rif.reg_we), 32'd0);
        check("rst_sda",   32'(sda), 32'd1);

        // Basic write with auto-increment.
        dq = '{8'hA5, 8'h3C};
        do_write(DEV, 8'h05, dq, 1'b0, acks);
        model_write(8'h05, dq);
        check("wr_acks", 32'(acks), 32'd4);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ptr",  32'(rif.reg_addr), 32'h07);
        i2c_stop();
        check("wr_busy_stop", 32'(busy), 32'd0);
        check_writes("wr");

        // Wrong address: never driven low, nothing written.
        low_before = dut_low_cnt;
        dq = '{8'h77};
        do_write(7'h1B, 8'h40, dq, 1'b1, acks);
        check("bad_acks", 32'(acks), 32'd0);
        check("bad_sda_low", 32'(dut_low_cnt - low_before), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        check_writes("bad");

        // Read with repeated START: master ACKs first byte, NACKs second.
        dq = '{8'h5A, 8'hC3};
        do_write(DEV, 8'h10, dq, 1'b1, acks);
        model_write(8'h10, dq);
        check_writes("rdpre");
        do_read(8'h10, 2, got, acks);
        check("rd_acks", 32'(acks), 32'd3);
        check("rd_b0", 32'(got[0]), 32'(mem_model[8'h10]));
        check("rd_b1", 32'(got[1]), 32'(mem_model[8'h11]));
        check("rd_sda_rel", 32'(sda), 32'd1);
        check("rd_ptr", 32'(rif.reg_addr), 32'h11);
        check("rd_busy", 32'(busy), 32'd0);
        i2c_stop();
        check_writes("rd");

        // Pointer wrap 8'hFF -> 8'h00.
        dq = '{8'h11, 8'h22};
        do_write(DEV, 8'hFF, dq, 1'b1, acks);
        model_write(8'hFF, dq);
        check("wrap_acks", 32'(acks), 32'd4);
        check_writes("wrap");

        // Reset during the 4th bit of a data byte (0xB5: bits 1,0,1,1).
        i2c_start();
        write_byte({DEV, 1'b0}, a);
        write_byte(8'h60, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        m_sda_low = 1'b0; wq(Q);
        scl = 1'b1;       wq(Q);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_sda", 32'(sda), 32'd1);
        check("rst_mid_state", 32'(dut.state_q), 32'(StIdle));
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ptr", 32'(rif.reg_addr), 32'd0);
        wq(3);
        rst_n = 1'b1;
        wq(Q);
        check_writes("rst_mid");
        dq = '{8'h77};
        do_write(DEV, 8'h20, dq, 1'b1, acks);
        model_write(8'h20, dq);
        check("post_rst_acks", 32'(acks), 32'd3);
        check_writes("post_rst");

        // STOP in the middle of a data byte.
        i2c_start();
        write_byte({DEV, 1'b0}, a);
        write_byte(8'h30, a);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        check("stop_mid_state", 32'(dut.state_q), 32'(StIdle));
        check("stop_mid_busy", 32'(busy), 32'd0);
        check_writes("stop_mid");

        // Randomised write-then-read-back against the model.
        for (int t = 0; t < 4; t++) begin
            start = 8'($urandom_range(0, 255));
            n     = int'($urandom_range(1, 4));
            dq.delete();
            repeat (n) dq.push_back(8'($urandom));
            do_write(DEV, start, dq, 1'b1, acks);
            model_write(start, dq);
            check("rnd_wacks", 32'(acks), 32'(n + 2));
            check("rnd_wptr", 32'(rif.reg_addr), 32'(start + 8'(n)));
            check_writes("rnd");
            do_read(start, n, got, acks);
            check("rnd_racks", 32'(acks), 32'd3);
            ea = start;
            foreach (got[i]) begin
                check("rnd_rbyte", 32'(got[i]), 32'(mem_model[ea]));
                ea = ea + 8'd1;
            end
            check("rnd_rptr", 32'(rif.reg_addr), 32'(start + 8'(n - 1)));
            i2c_stop();
        end

        check("we_one_cycle", 32'(long_pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
